// File: rtl/count_mon_pkg.sv
// Shared types and constants for the two-bit counter sequence monitor.
// The monitor FSM encoding and the counter width live here so every block agrees on them.
package count_mon_pkg;

    localparam int CNT_W        = 2;
    localparam int LOCK_LEN_MAX = 15;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } mon_state_t;

    // Expected successor of a counter value; wraps 3 -> 0 naturally at CNT_W bits.
    function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/phase_decode.sv
// Registered 2-to-4 one-hot decode of the sampled counter value.
// Synchronous active-high reset clears the decode to all zeros.
module phase_decode
    import count_mon_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic [CNT_W-1:0] cnt,
    output logic [3:0]       phase
);

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase <= 4'b0000;
        end else begin
            phase <= 4'b0001 << cnt;
        end
    end

endmodule

// File: rtl/count_seq_monitor.sv
// Checks that {Q_A,Q_B} steps +1 mod 4 per clock: locks, counts wraps and flags faults.
// Define COUNT_MON_ERRCNT_EN to add the saturating Err_Count output.
module count_seq_monitor
    import count_mon_pkg::*;
#(
    parameter int WRAP_W   = 8,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Q_A,
    input  logic              Q_B,
    input  logic              Clr_Err,
    output logic              Locked,
    output logic              Err,
    output logic              Err_Sticky,
    output logic [WRAP_W-1:0] Wraps,
    output logic [3:0]        Phase
`ifdef COUNT_MON_ERRCNT_EN
    ,
    output logic [ERR_W-1:0]  Err_Count
`endif
);

    localparam int LOCK_CLAMP = (LOCK_LEN < 1) ? 1 :
                                (LOCK_LEN > LOCK_LEN_MAX) ? LOCK_LEN_MAX : LOCK_LEN;
    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CLAMP);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] prev_q;
    mon_state_t       state_q, state_d;
    logic [3:0]       good_q, good_d;
    logic             valid;
    logic             fault;
    logic             wrap;

    assign cnt   = {Q_A, Q_B};
    assign valid = (cnt == next_cnt(prev_q));

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        fault   = 1'b0;
        wrap    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                state_d = ST_ACQ;
                good_d  = '0;
            end
            ST_ACQ: begin
                if (valid) begin
                    good_d = good_q + 4'd1;
                    if (good_d == LOCK_TGT) state_d = ST_LOCK;
                end else begin
                    good_d = '0;
                end
            end
            ST_LOCK: begin
                if (valid) begin
                    // A valid step landing on 0 can only have come from 3.
                    wrap = (cnt == '0);
                end else begin
                    fault   = 1'b1;
                    good_d  = '0;
                    state_d = ST_ACQ;
                end
            end
            default: begin
                state_d = ST_SYNC;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_SYNC;
            good_q  <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            prev_q  <= cnt;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Locked     <= 1'b0;
            Err        <= 1'b0;
            Err_Sticky <= 1'b0;
            Wraps      <= '0;
        end else begin
            Locked <= (state_d == ST_LOCK);
            Err    <= fault;
            Wraps  <= Wraps + WRAP_W'(wrap);
            // A fault in the same cycle as a clear still leaves the sticky bit set.
            if (fault)        Err_Sticky <= 1'b1;
            else if (Clr_Err) Err_Sticky <= 1'b0;
        end
    end

`ifdef COUNT_MON_ERRCNT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Err_Count <= '0;
        end else if (fault) begin
            if (Clr_Err)             Err_Count <= ERR_W'(1);
            else if (Err_Count != '1) Err_Count <= Err_Count + ERR_W'(1);
        end else if (Clr_Err) begin
            Err_Count <= '0;
        end
    end
`else
    logic [31:0] unused_err_w;
    assign unused_err_w = ERR_W;
`endif

    phase_decode u_phase_decode (
        .Clock (Clock),
        .Reset (Reset),
        .cnt   (cnt),
        .phase (Phase)
    );

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: lock, wraps, faults, clear, saturation and reset.
// Err_Count is checked only when COUNT_MON_ERRCNT_EN is defined.
module tb_count_seq_monitor;

    logic       Clock;
    logic       Reset;
    logic       Q_A;
    logic       Q_B;
    logic       Clr_Err;
    logic       Locked;
    logic       Err;
    logic       Err_Sticky;
    logic [7:0] Wraps;
    logic [3:0] Phase;
`ifdef COUNT_MON_ERRCNT_EN
    logic [3:0] Err_Count;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] cur      = 2'd0;

    count_seq_monitor #(
        .WRAP_W   (8),
        .LOCK_LEN (4),
        .ERR_W    (4)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Q_A        (Q_A),
        .Q_B        (Q_B),
        .Clr_Err    (Clr_Err),
        .Locked     (Locked),
        .Err        (Err),
        .Err_Sticky (Err_Sticky),
        .Wraps      (Wraps),
        .Phase      (Phase)
`ifdef COUNT_MON_ERRCNT_EN
        ,
        .Err_Count  (Err_Count)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one counter sample, let the edge take it, then settle before sampling outputs.
    task automatic step(input logic [1:0] c, input logic clr);
        {Q_A, Q_B} = c;
        Clr_Err    = clr;
        cur        = c;
        @(posedge Clock);
        #1;
    endtask

    task automatic adv();
        step(cur + 2'd1, 1'b0);
    endtask

    initial begin
        Reset   = 1'b1;
        Q_A     = 1'b0;
        Q_B     = 1'b0;
        Clr_Err = 1'b0;

        // Reset values
        step(2'd0, 1'b0);
        step(2'd0, 1'b0);
        check("rst_locked", Locked, 0);
        check("rst_err", Err, 0);
        check("rst_sticky", Err_Sticky, 0);
        check("rst_wraps", Wraps, 0);
        check("rst_phase", Phase, 0);
`ifdef COUNT_MON_ERRCNT_EN
        check("rst_errcnt", Err_Count, 0);
`endif

        // Acquire: SYNC at edge 1, Locked at edge 5
        Reset = 1'b0;
        step(2'd0, 1'b0);
        check("sync_phase", Phase, 4'b0001);
        check("sync_locked", Locked, 0);
        adv(); adv(); adv();
        check("acq_not_locked", Locked, 0);
        check("acq_no_err", Err, 0);
        adv();
        check("lock_edge5", Locked, 1);
        check("lock_no_wrap", Wraps, 0);
        check("lock_phase", Phase, 4'b0001);
        adv(); adv(); adv();
        check("pre_wrap", Wraps, 0);
        adv();
        check("wrap_1", Wraps, 1);
        check("wrap_no_err", Err, 0);
        check("wrap_locked", Locked, 1);

        // Skip fault: 0 -> 2
        step(2'd2, 1'b0);
        check("skip_err", Err, 1);
        check("skip_sticky", Err_Sticky, 1);
        check("skip_locked", Locked, 0);
        check("skip_phase", Phase, 4'b0100);
        adv();
        check("skip_err_pulse", Err, 0);
        check("skip_sticky_held", Err_Sticky, 1);
        adv(); adv();
        check("relock_early", Locked, 0);
        adv();
        check("relock", Locked, 1);
        check("relock_wraps", Wraps, 1);

        // Hold fault: counter stays at 1 for two edges
        adv(); adv();
        check("wrap_2", Wraps, 2);
        adv();
        step(2'd1, 1'b0);
        check("hold_err", Err, 1);
        check("hold_locked", Locked, 0);
        step(2'd1, 1'b0);
        check("hold2_no_err", Err, 0);
        check("hold2_locked", Locked, 0);
        adv(); adv(); adv(); adv();
        check("hold_relock", Locked, 1);
        check("hold_wraps", Wraps, 2);

        // Clear alone, then clear together with a fault
        step(2'd2, 1'b1);
        check("clr_sticky", Err_Sticky, 0);
        check("clr_no_err", Err, 0);
        check("clr_locked", Locked, 1);
`ifdef COUNT_MON_ERRCNT_EN
        check("clr_errcnt", Err_Count, 0);
`endif
        step(2'd0, 1'b1);
        check("clrfault_err", Err, 1);
        check("clrfault_sticky", Err_Sticky, 1);
`ifdef COUNT_MON_ERRCNT_EN
        check("clrfault_errcnt", Err_Count, 1);
`endif

        // Twenty more faults to drive the error count into saturation
        for (int i = 0; i < 20; i++) begin
            adv(); adv(); adv(); adv();
            check("sat_relock", Locked, 1);
            step(cur + 2'd2, 1'b0);
            check("sat_err", Err, 1);
        end
        check("sat_sticky", Err_Sticky, 1);
`ifdef COUNT_MON_ERRCNT_EN
        check("sat_errcnt", Err_Count, 15);
`endif
        step(cur + 2'd1, 1'b1);
        check("sat_clr_sticky", Err_Sticky, 0);
`ifdef COUNT_MON_ERRCNT_EN
        check("sat_clr_errcnt", Err_Count, 0);
`endif

        // Wrap counter rollover at 256
        Reset = 1'b1;
        step(2'd0, 1'b0);
        Reset = 1'b0;
        step(2'd0, 1'b0);
        adv(); adv(); adv(); adv();
        check("roll_locked", Locked, 1);
        for (int i = 0; i < 255; i++) begin
            adv(); adv(); adv(); adv();
        end
        check("roll_255", Wraps, 255);
        adv(); adv(); adv(); adv();
        check("roll_256", Wraps, 0);
        adv(); adv(); adv(); adv();
        check("roll_257", Wraps, 1);

        // Reset while locked with Wraps = 5
        for (int i = 0; i < 4; i++) begin
            adv(); adv(); adv(); adv();
        end
        check("mid_wraps5", Wraps, 5);
        check("mid_locked", Locked, 1);
        Reset = 1'b1;
        adv();
        check("mid_rst_locked", Locked, 0);
        check("mid_rst_err", Err, 0);
        check("mid_rst_sticky", Err_Sticky, 0);
        check("mid_rst_wraps", Wraps, 0);
        check("mid_rst_phase", Phase, 0);
        Reset = 1'b0;
        adv();
        check("mid_sync_phase", Phase, 4'b0100);
        adv(); adv(); adv();
        check("mid_acq_locked", Locked, 0);
        adv();
        check("mid_relock", Locked, 1);
        check("mid_relock_wraps", Wraps, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
